// File: rtl/seq_alu.sv
`default_nettype none
// =============================================================================
// Module   : seq_alu
// Brief    : Registered execute-stage ALU with iterative signed/unsigned
//            multiply and divide writing a HI/LO register pair.
// Revision : 1.0 - initial release
// =============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] c_op_and   = OPW'(4'b0000);
    localparam logic [OPW-1:0] c_op_or    = OPW'(4'b0001);
    localparam logic [OPW-1:0] c_op_add   = OPW'(4'b0010);
    localparam logic [OPW-1:0] c_op_xor   = OPW'(4'b0011);
    localparam logic [OPW-1:0] c_op_sll   = OPW'(4'b0100);
    localparam logic [OPW-1:0] c_op_srl   = OPW'(4'b0101);
    localparam logic [OPW-1:0] c_op_sub   = OPW'(4'b0110);
    localparam logic [OPW-1:0] c_op_slt   = OPW'(4'b0111);
    localparam logic [OPW-1:0] c_op_sltu  = OPW'(4'b1000);
    localparam logic [OPW-1:0] c_op_multu = OPW'(4'b1001);
    localparam logic [OPW-1:0] c_op_mult  = OPW'(4'b1010);
    localparam logic [OPW-1:0] c_op_divu  = OPW'(4'b1011);
    localparam logic [OPW-1:0] c_op_nor   = OPW'(4'b1100);
    localparam logic [OPW-1:0] c_op_sra   = OPW'(4'b1101);
    localparam logic [OPW-1:0] c_op_div   = OPW'(4'b1110);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 div_op_q, div_op_d;
    logic                 dbz_case_q, dbz_case_d;
    logic [WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 zero_q, zero_d;
    logic                 overflow_q, overflow_d;
    logic                 div_by_zero_q, div_by_zero_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     w_sum, w_diff, w_res;
    logic                 w_ovf;
    logic [SHW-1:0]       w_shamt;
    logic                 w_is_mul, w_is_div, w_signed;
    logic                 w_sign_a, w_sign_b;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_mul_sum, w_trial, w_trial_diff;
    logic                 w_take;
    logic [WIDTH-1:0]     w_rem_next;
    logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod_neg;

    assign w_sum    = SrcA + SrcB;
    assign w_diff   = SrcA - SrcB;
    assign w_shamt  = SrcB[SHW-1:0];
    assign w_is_mul = (operation == c_op_multu) || (operation == c_op_mult);
    assign w_is_div = (operation == c_op_divu) || (operation == c_op_div);
    assign w_signed = (operation == c_op_mult) || (operation == c_op_div);
    assign w_sign_a = w_signed & SrcA[WIDTH-1];
    assign w_sign_b = w_signed & SrcB[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -SrcA : SrcA;
    assign w_mag_b  = w_sign_b ? -SrcB : SrcB;

    // Shift-add step: {accumulator, multiplier} shifts right, product fills from the top
    assign w_mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, operand_q} : '0);
    assign w_mul_next = {w_mul_sum, work_q[WIDTH-1:1]};

    // Restoring step: {remainder, dividend} shifts left, quotient bits enter at the bottom
    assign w_trial      = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign w_trial_diff = w_trial - {1'b0, operand_q};
    assign w_take       = ~w_trial_diff[WIDTH];
    assign w_rem_next   = w_take ? w_trial_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_div_next   = {w_rem_next, work_q[WIDTH-2:0], w_take};
    assign w_prod_neg   = -work_q;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (operation)
            c_op_add: begin
                w_res = w_sum;
                w_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            c_op_and:  w_res = SrcA & SrcB;
            c_op_or:   w_res = SrcA | SrcB;
            c_op_nor:  w_res = ~(SrcA | SrcB);
            c_op_xor:  w_res = SrcA ^ SrcB;
            c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            c_op_sll:  w_res = SrcA << w_shamt;
            c_op_srl:  w_res = SrcA >> w_shamt;
            c_op_sra:  w_res = $signed(SrcA) >>> w_shamt;
            default:   w_res = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_d        = work_q;
        operand_d     = operand_q;
        neg_lo_d      = neg_lo_q;
        neg_hi_d      = neg_hi_q;
        div_op_d      = div_op_q;
        dbz_case_d    = dbz_case_q;
        alu_result_d  = alu_result_q;
        zero_d        = zero_q;
        overflow_d    = overflow_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (w_is_mul) begin
                        state_d    = S_MUL;
                        cnt_d      = SHW'(WIDTH-1);
                        work_d     = {{WIDTH{1'b0}}, w_mag_b};
                        operand_d  = w_mag_a;
                        neg_lo_d   = w_sign_a ^ w_sign_b;
                        div_op_d   = 1'b0;
                        dbz_case_d = 1'b0;
                    end else if (w_is_div) begin
                        div_op_d = 1'b1;
                        neg_lo_d = w_sign_a ^ w_sign_b;
                        neg_hi_d = w_sign_a;
                        if (SrcB == '0) begin
                            state_d    = S_FIX;
                            dbz_case_d = 1'b1;
                            work_d     = {{WIDTH{1'b0}}, SrcA};
                        end else begin
                            state_d    = S_DIV;
                            cnt_d      = SHW'(WIDTH-1);
                            dbz_case_d = 1'b0;
                            work_d     = {{WIDTH{1'b0}}, w_mag_a};
                            operand_d  = w_mag_b;
                        end
                    end else begin
                        alu_result_d = w_res;
                        zero_d       = (w_res == '0);
                        overflow_d   = w_ovf;
                        done_d       = 1'b1;
                    end
                end
            end
            S_MUL: begin
                work_d = w_mul_next;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_DIV: begin
                work_d = w_div_next;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dbz_case_q) begin
                    hi_d          = work_q[WIDTH-1:0];
                    lo_d          = '1;
                    div_by_zero_d = 1'b1;
                end else if (div_op_q) begin
                    lo_d          = neg_lo_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
                    hi_d          = neg_hi_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
                    div_by_zero_d = 1'b0;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? w_prod_neg : work_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            work_q        <= '0;
            operand_q     <= '0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            div_op_q      <= 1'b0;
            dbz_case_q    <= 1'b0;
            alu_result_q  <= '0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            work_q        <= work_d;
            operand_q     <= operand_d;
            neg_lo_q      <= neg_lo_d;
            neg_hi_q      <= neg_hi_d;
            div_op_q      <= div_op_d;
            dbz_case_q    <= dbz_case_d;
            alu_result_q  <= alu_result_d;
            zero_q        <= zero_d;
            overflow_q    <= overflow_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
        end
    end

    assign ALUResult = alu_result_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign Zero      = zero_q;
    assign Overflow  = overflow_q;
    assign DivByZero = div_by_zero_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// =============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
// Revision : 1.0 - initial release
// =============================================================================
module tb_seq_alu;

    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001, OP_MULT = 4'b1010, OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100, OP_SRA = 4'b1101, OP_DIV = 4'b1110;
    localparam logic [3:0] OP_NONE = 4'b1111;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] srca, srcb, alu_result, hi, lo;
    logic        zero, overflow, div_by_zero, busy, done;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8, hi8, lo8;
    logic        zero8, ovf8, dbz8, busy8, done8;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32), .OPW(4)) u_dut32 (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .SrcA(srca), .SrcB(srcb), .ALUResult(alu_result), .HI(hi), .LO(lo),
        .Zero(zero), .Overflow(overflow), .DivByZero(div_by_zero),
        .busy(busy), .done(done)
    );

    seq_alu #(.WIDTH(8), .OPW(4)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .operation(op8),
        .SrcA(a8), .SrcB(b8), .ALUResult(res8), .HI(hi8), .LO(lo8),
        .Zero(zero8), .Overflow(ovf8), .DivByZero(dbz8),
        .busy(busy8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Operands are scrambled after the start cycle so only latched values count
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; operation = op; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0; operation = OP_NONE; srca = 32'hA5A5_5A5A; srcb = 32'h0F0F_F0F0;
    endtask

    task automatic wait_done32(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int cycles);
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; op8 = OP_NONE; a8 = 8'h5A; b8 = 8'hC3;
        cycles = 1;
        while (done8 !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; operation = OP_NONE; srca = '0; srcb = '0;
        start8 = 1'b0; op8 = OP_NONE; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({alu_result, hi, lo, zero, overflow, div_by_zero, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset32: got res=%h hi=%h lo=%h z=%b v=%b dbz=%b busy=%b done=%b, expected all 0",
                     alu_result, hi, lo, zero, overflow, div_by_zero, busy, done);
        end
        checks++;
        if ({res8, hi8, lo8, zero8, ovf8, dbz8, busy8, done8} !== '0) begin
            errors++;
            $display("FAIL reset8: got res=%h hi=%h lo=%h z=%b v=%b dbz=%b busy=%b done=%b, expected all 0",
                     res8, hi8, lo8, zero8, ovf8, dbz8, busy8, done8);
        end
        reset = 1'b0;
        issue32(OP_MULT, 32'd5, 32'd5);
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_mult: got %b expected 1", busy);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({alu_result, hi, lo, zero, overflow, div_by_zero, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset_abort: got res=%h hi=%h lo=%h busy=%b done=%b, expected all 0",
                     alu_result, hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        issue32(OP_ADD, 32'd5, 32'd7);
        checks++;
        if ({alu_result, done, zero, hi, lo} !== {32'd12, 1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL add_after_reset: got res=%h done=%b z=%b hi=%h lo=%h, expected res=0000000c done=1 z=0 hi/lo=0",
                     alu_result, done, zero, hi, lo);
        end
    endtask

    task automatic test_add_sub();
        issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if ({alu_result, overflow, zero, done} !== {32'h8000_0000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got res=%h v=%b z=%b done=%b, expected 80000000 v=1 z=0 done=1",
                     alu_result, overflow, zero, done);
        end
        issue32(OP_SUB, 32'd3, 32'd3);
        checks++;
        if ({alu_result, overflow, zero} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got res=%h v=%b z=%b, expected 00000000 v=0 z=1", alu_result, overflow, zero);
        end
        issue32(OP_SUB, 32'h8000_0000, 32'h0000_0001);
        checks++;
        if ({alu_result, overflow, zero} !== {32'h7FFF_FFFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_ovf: got res=%h v=%b z=%b, expected 7fffffff v=1 z=0", alu_result, overflow, zero);
        end
        issue32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        checks++;
        if ({alu_result, overflow, zero} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_wrap: got res=%h v=%b z=%b, expected 00000000 v=0 z=1", alu_result, overflow, zero);
        end
        issue32(OP_ADD, 32'd5, 32'd5);
        checks++;
        if ({alu_result, overflow, zero} !== {32'd10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_equal_ops: got res=%h v=%b z=%b, expected 0000000a v=0 z=0", alu_result, overflow, zero);
        end
    endtask

    task automatic test_compare_shift();
        issue32(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if (alu_result !== 32'd1) begin
            errors++;
            $display("FAIL slt: got %h expected 00000001", alu_result);
        end
        issue32(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        checks++;
        if ({alu_result, zero} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL sltu: got res=%h z=%b expected 00000000 z=1", alu_result, zero);
        end
        issue32(OP_SRA, 32'h8000_0000, 32'd4);
        checks++;
        if (alu_result !== 32'hF800_0000) begin
            errors++;
            $display("FAIL sra: got %h expected f8000000", alu_result);
        end
        issue32(OP_SRL, 32'h8000_0000, 32'd4);
        checks++;
        if (alu_result !== 32'h0800_0000) begin
            errors++;
            $display("FAIL srl: got %h expected 08000000", alu_result);
        end
        issue32(OP_SLL, 32'd1, 32'h0000_0024);
        checks++;
        if (alu_result !== 32'h0000_0010) begin
            errors++;
            $display("FAIL sll_masked: got %h expected 00000010", alu_result);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, alu_result} !== {1'b0, 1'b0, 32'h0000_0010}) begin
            errors++;
            $display("FAIL done_single_pulse: got done=%b busy=%b res=%h expected done=0 busy=0 res=00000010",
                     done, busy, alu_result);
        end
    endtask

    task automatic test_logic();
        issue32(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (alu_result !== 32'hF000_F000) begin
            errors++;
            $display("FAIL and: got %h expected f000f000", alu_result);
        end
        issue32(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (alu_result !== 32'hFFF0_FFF0) begin
            errors++;
            $display("FAIL or: got %h expected fff0fff0", alu_result);
        end
        issue32(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (alu_result !== 32'h0FF0_0FF0) begin
            errors++;
            $display("FAIL xor: got %h expected 0ff00ff0", alu_result);
        end
        issue32(OP_NOR, 32'h0, 32'h0);
        checks++;
        if ({alu_result, zero} !== {32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("FAIL nor: got res=%h z=%b expected ffffffff z=0", alu_result, zero);
        end
        issue32(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        issue32(OP_NONE, 32'h1234_5678, 32'h1);
        checks++;
        if ({alu_result, zero, overflow, done, hi, lo} !== {32'h0, 1'b1, 1'b0, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL op_1111: got res=%h z=%b v=%b done=%b hi=%h lo=%h expected 0 z=1 v=0 done=1 hi/lo=0",
                     alu_result, zero, overflow, done, hi, lo);
        end
    endtask

    task automatic test_mult();
        int  cycles;
        logic seen;
        issue32(OP_OR, 32'h1234_0000, 32'h0000_5678);
        @(negedge clk);
        start = 1'b1; operation = OP_MULT; srca = 32'hFFFF_FFFD; srcb = 32'd7;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) seen = 1'b1;
            start = (cycles == 5); operation = OP_ADD; srca = 32'd1; srcb = 32'd1;
        end
        start = 1'b0;
        checks++;
        if (cycles !== 34) begin
            errors++;
            $display("FAIL mult_latency: got %0d cycles expected 34", cycles);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg: got hi=%h lo=%h expected ffffffff ffffffeb", hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, alu_result} !== {1'b0, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mult_ignored_start: got done=%b busy=%b res=%h expected done=0 busy=0 res=12345678",
                     done, busy, alu_result);
        end
        issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32(cycles);
        checks++;
        if ({cycles, hi, lo} !== {32'd34, 64'hFFFF_FFFE_0000_0001}) begin
            errors++;
            $display("FAIL multu_max: got cycles=%0d hi=%h lo=%h expected 34 fffffffe 00000001", cycles, hi, lo);
        end
    endtask

    task automatic test_div();
        int cycles;
        issue32(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done32(cycles);
        checks++;
        if ({cycles, hi, lo, div_by_zero} !== {32'd34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
            errors++;
            $display("FAIL div_neg: got cycles=%0d hi=%h lo=%h dbz=%b expected 34 ffffffff fffffffd 0",
                     cycles, hi, lo, div_by_zero);
        end
        issue32(OP_DIVU, 32'd7, 32'd0);
        wait_done32(cycles);
        checks++;
        if ({cycles, hi, lo, div_by_zero} !== {32'd2, 32'd7, 32'hFFFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL divu_by_zero: got cycles=%0d hi=%h lo=%h dbz=%b expected 2 00000007 ffffffff 1",
                     cycles, hi, lo, div_by_zero);
        end
        issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done32(cycles);
        checks++;
        if ({cycles, hi, lo, div_by_zero} !== {32'd34, 32'h0, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL div_most_neg: got cycles=%0d hi=%h lo=%h dbz=%b expected 34 00000000 80000000 0",
                     cycles, hi, lo, div_by_zero);
        end
        issue32(OP_DIVU, 32'hFFFF_FFFF, 32'd10);
        wait_done32(cycles);
        checks++;
        if ({hi, lo, alu_result} !== {32'd5, 32'h1999_9999, 32'h1234_5678}) begin
            errors++;
            $display("FAIL divu: got hi=%h lo=%h res=%h expected 00000005 19999999 12345678", hi, lo, alu_result);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; operation = OP_ADD; srca = 32'd1; srcb = 32'd2;
        @(negedge clk);
        checks++;
        if ({done, alu_result} !== {1'b1, 32'd3}) begin
            errors++;
            $display("FAIL b2b_add: got done=%b res=%h expected done=1 res=00000003", done, alu_result);
        end
        operation = OP_AND; srca = 32'hC; srcb = 32'hA;
        @(negedge clk);
        checks++;
        if ({done, alu_result} !== {1'b1, 32'd8}) begin
            errors++;
            $display("FAIL b2b_and: got done=%b res=%h expected done=1 res=00000008", done, alu_result);
        end
        operation = OP_OR;
        @(negedge clk);
        checks++;
        if ({done, alu_result} !== {1'b1, 32'hE}) begin
            errors++;
            $display("FAIL b2b_or: got done=%b res=%h expected done=1 res=0000000e", done, alu_result);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, hi, lo} !== {1'b0, 32'd5, 32'h1999_9999}) begin
            errors++;
            $display("FAIL b2b_end: got done=%b hi=%h lo=%h expected done=0 hi=00000005 lo=19999999", done, hi, lo);
        end
    endtask

    task automatic test_width8();
        int cycles;
        issue8(OP_MULTU, 8'hFF, 8'hFF, cycles);
        checks++;
        if ({cycles, hi8, lo8} !== {32'd10, 8'hFE, 8'h01}) begin
            errors++;
            $display("FAIL w8_multu: got cycles=%0d hi=%h lo=%h expected 10 fe 01", cycles, hi8, lo8);
        end
        issue8(OP_MULT, 8'h80, 8'h80, cycles);
        checks++;
        if ({hi8, lo8} !== {8'h40, 8'h00}) begin
            errors++;
            $display("FAIL w8_mult_most_neg: got hi=%h lo=%h expected 40 00", hi8, lo8);
        end
        issue8(OP_DIV, 8'h9C, 8'd7, cycles);
        checks++;
        if ({cycles, hi8, lo8, dbz8} !== {32'd10, 8'hFE, 8'hF2, 1'b0}) begin
            errors++;
            $display("FAIL w8_div: got cycles=%0d hi=%h lo=%h dbz=%b expected 10 fe f2 0", cycles, hi8, lo8, dbz8);
        end
        issue8(OP_SRA, 8'h80, 8'h0B, cycles);
        checks++;
        if ({cycles, res8, zero8, ovf8, busy8} !== {32'd1, 8'hF0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL w8_sra: got cycles=%0d res=%h z=%b v=%b busy=%b expected 1 f0 0 0 0",
                     cycles, res8, zero8, ovf8, busy8);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare_shift();
        test_logic();
        test_mult();
        test_div();
        test_back_to_back();
        test_width8();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
